// File: rtl/crc32_pkg.sv
// Shared definitions for the CRC32 feed sequencer: write-size encodings,
// the size-to-byte-count decode, the sequencer state enum and the CRC seed.
package crc32_pkg;

    localparam logic [1:0]  SZ_BYTE    = 2'b00;
    localparam logic [1:0]  SZ_HALF    = 2'b01;
    localparam logic [1:0]  SZ_WORD    = 2'b10;
    localparam logic [1:0]  SZ_ILLEGAL = 2'b11;

    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;

    // Queue entry layout: {data[31:0], nbytes[2:0]}
    localparam int ENTRY_W = 35;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_INIT = 2'd2
    } seq_state_e;

    // Zero marks an illegal size; such writes are never enqueued.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] nb;
        case (size)
            SZ_BYTE: nb = 3'd1;
            SZ_HALF: nb = 3'd2;
            SZ_WORD: nb = 3'd4;
            default: nb = 3'd0;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/crc32_wr_fifo.sv
// DEPTH-entry synchronous write queue with flush; exposes the head and the
// entry behind it so the sequencer can chain entries without a bubble.
module crc32_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 35
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               head_o,
    output logic [W-1:0]               next_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [LW-1:0] level_q;
    logic [AW-1:0] wr_addr;

    // A push in the flush cycle lands in slot 0 of the emptied queue.
    assign wr_addr = flush_i ? '0 : wr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push_i ? AW'(1) : '0;
            level_q  <= push_i ? LW'(1) : '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_i) - LW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_addr] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + AW'(1)];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/crc32_feed_sequencer.sv
// Queues byte/halfword/word writes and serialises them LSB-first into a
// one-byte-per-cycle CRC engine, ordering re-init against in-flight data.
module crc32_feed_sequencer
    import crc32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    input  logic [1:0]             wr_size,
    input  logic [31:0]            wr_data,
    output logic                   wr_ready,
    input  logic                   init_req,
    input  logic                   eng_ready,
    output logic                   eng_valid,
    output logic [7:0]             eng_byte,
    output logic                   eng_init,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       byte_cnt,
    output logic                   err
);

    localparam int LW = $clog2(DEPTH) + 1;

    // Handshake: a write transfers on any edge where wr_valid && wr_ready;
    // a byte transfers to the engine on any edge where eng_valid && eng_ready.
    // eng_valid/eng_byte only change after a transfer, an init or a reset.

    seq_state_e          state_q, state_d;
    logic [31:0]         shift_q, shift_d;
    logic [2:0]          idx_q,   idx_d;
    logic [2:0]          nb_q,    nb_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                err_q,   err_d;

    logic [ENTRY_W-1:0]  fifo_head;
    logic [ENTRY_W-1:0]  fifo_next;
    logic [LW-1:0]       fifo_level;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;

    logic [2:0]          wr_nbytes;
    logic                wr_ok;
    logic                wr_legal;
    logic                push;
    logic                valid_c;
    logic                fire;
    logic                last;

    assign wr_nbytes = size_to_nbytes(wr_size);
    assign wr_legal  = (wr_nbytes != 3'd0);
    assign wr_ready  = !fifo_full;
    assign wr_ok     = wr_valid && wr_ready;
    assign push      = wr_ok && wr_legal;

    // The entry being fed keeps its queue slot until its last byte goes out.
    crc32_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (init_req),
        .wdata_i ({wr_data, wr_nbytes}),
        .head_o  (fifo_head),
        .next_o  (fifo_next),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // An init request kills the byte on offer so it never reaches the engine.
    assign valid_c = (state_q == ST_FEED) && !init_req;
    assign fire    = valid_c && eng_ready;
    assign last    = ((idx_q + 3'd1) == nb_q);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        nb_d    = nb_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pop     = 1'b0;

        if (init_req) begin
            state_d = ST_INIT;
            shift_d = '0;
            idx_d   = '0;
            nb_d    = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_INIT: begin
                    idx_d = '0;
                    if (!fifo_empty) begin
                        state_d = ST_FEED;
                        shift_d = fifo_head[34:3];
                        nb_d    = fifo_head[2:0];
                    end else if (push) begin
                        state_d = ST_FEED;
                        shift_d = wr_data;
                        nb_d    = wr_nbytes;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FEED: begin
                    if (fire) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        shift_d = {8'h00, shift_q[31:8]};
                        idx_d   = idx_q + 3'd1;
                        if (last) begin
                            pop   = 1'b1;
                            idx_d = '0;
                            if (fifo_level > LW'(1)) begin
                                shift_d = fifo_next[34:3];
                                nb_d    = fifo_next[2:0];
                            end else if (push) begin
                                shift_d = wr_data;
                                nb_d    = wr_nbytes;
                            end else begin
                                state_d = ST_IDLE;
                                shift_d = '0;
                                nb_d    = '0;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Evaluated after the init clear so a same-cycle illegal write still flags.
        if (wr_ok && !wr_legal) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            nb_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            nb_q    <= nb_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign eng_valid = valid_c;
    assign eng_byte  = (state_q == ST_FEED) ? shift_q[7:0] : 8'h00;
    assign eng_init  = (state_q == ST_INIT);
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign level     = fifo_level;
    assign byte_cnt  = cnt_q;
    assign err       = err_q;

endmodule
